// File: rtl/motoro3_commutate.sv
// Six-step commutation and PWM generator for the motoro3 3-phase bridge.
// Owns step/sub-step timing, PWM period and duty, and commutation dead time.
module motoro3_commutate #(
  parameter logic [7:0] DEADTIME = 8'd8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        m3c_enable,
  input  logic [24:0] m3r_stepCNT_speedSET,
  input  logic [7:0]  m3r_power_percent,
  input  logic [11:0] m3r_pwmLenWant,
  input  logic [11:0] m3r_pwmMinMask,
  input  logic [1:0]  m3r_stepSplitMax,
  output logic [2:0]  m3c_phase,
  output logic        m3c_stepStart,
  output logic [1:0]  m3c_subStep,
  output logic        m3c_pwmOn,
  output logic [2:0]  m3c_gateH,
  output logic [2:0]  m3c_gateL
);

  logic        en_q;
  logic [24:0] stepCnt_q, stepCnt_d, S_q, S_d;
  logic [2:0]  phase_q, phase_d;
  logic        ss_q, ss_d;
  logic [22:0] sub_q, sub_d;
  logic [1:0]  subStep_q, subStep_d, split_q, split_d;
  logic [11:0] perCnt_q, perCnt_d, L_q, L_d, On_q, On_d;
  logic        pwm_q, pwm_d;
  logic [7:0]  dead_q, dead_d;
  logic [2:0]  gateH_q, gateH_d, gateL_q, gateL_d;

  logic        rise, stepWrap, stepLoad, subWrap, perLoad;
  logic [11:0] lenEff, onEff;
  logic [22:0] qEff;
  logic [24:0] speedEff;
  logic [5:0]  tbl;

  // On-time with minimum pulse/gap masking: too short -> off, too close to L -> fully on.
  function automatic logic [11:0] duty_sat(input logic [11:0] len, input logic [7:0] pct,
                                           input logic [11:0] mask);
    logic [19:0] p;
    logic [11:0] on, hi;
    p  = {8'd0, len} * {12'd0, pct};
    on = 12'(p >> 8);
    if (on > len) on = len;
    hi = (mask >= len) ? 12'd0 : len - mask;
    if (on < mask)    duty_sat = 12'd0;
    else if (on > hi) duty_sat = len;
    else              duty_sat = on;
  endfunction

  // {high[2:0], low[2:0]} per phase, bits ordered {C,B,A}.
  function automatic logic [5:0] gate_tbl(input logic [2:0] ph);
    case (ph)
      3'd0:    gate_tbl = {3'b001, 3'b010};
      3'd1:    gate_tbl = {3'b001, 3'b100};
      3'd2:    gate_tbl = {3'b010, 3'b100};
      3'd3:    gate_tbl = {3'b010, 3'b001};
      3'd4:    gate_tbl = {3'b100, 3'b001};
      3'd5:    gate_tbl = {3'b100, 3'b010};
      default: gate_tbl = 6'd0;
    endcase
  endfunction

  assign lenEff   = (m3r_pwmLenWant < 12'd2) ? 12'd2 : m3r_pwmLenWant;
  assign onEff    = duty_sat(lenEff, m3r_power_percent, m3r_pwmMinMask);
  assign speedEff = (m3r_stepCNT_speedSET == 25'd0) ? 25'd1 : m3r_stepCNT_speedSET;
  assign qEff     = (S_q[24:2] == 23'd0) ? 23'd1 : S_q[24:2];
  assign tbl      = gate_tbl(phase_q);

  always_comb begin
    rise      = m3c_enable & ~en_q;
    stepWrap  = en_q & (stepCnt_q == S_q - 25'd1);
    stepLoad  = rise | stepWrap;
    subWrap   = (sub_q == qEff - 23'd1);
    perLoad   = rise | (en_q & (perCnt_q == L_q - 12'd1));
    stepCnt_d = 25'd0;
    S_d       = S_q;
    split_d   = split_q;
    phase_d   = 3'd0;
    ss_d      = 1'b0;
    sub_d     = 23'd0;
    subStep_d = 2'd0;
    perCnt_d  = 12'd0;
    L_d       = L_q;
    On_d      = On_q;
    pwm_d     = 1'b0;
    dead_d    = 8'd0;
    gateH_d   = 3'd0;
    gateL_d   = 3'd0;
    if (m3c_enable) begin
      stepCnt_d = stepLoad ? 25'd0 : stepCnt_q + 25'd1;
      S_d       = stepLoad ? speedEff : S_q;
      split_d   = stepLoad ? m3r_stepSplitMax : split_q;
      phase_d   = rise ? 3'd0 :
                  stepWrap ? ((phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1) : phase_q;
      ss_d      = stepLoad;
      sub_d     = (stepLoad | subWrap) ? 23'd0 : sub_q + 23'd1;
      if (stepLoad)                             subStep_d = 2'd0;
      else if (subWrap && subStep_q < split_q)  subStep_d = subStep_q + 2'd1;
      else                                      subStep_d = subStep_q;
      perCnt_d  = perLoad ? 12'd0 : perCnt_q + 12'd1;
      L_d       = perLoad ? lenEff : L_q;
      On_d      = perLoad ? onEff : On_q;
      pwm_d     = ~rise & (perCnt_q < On_q);
      dead_d    = stepLoad ? DEADTIME : ((dead_q != 8'd0) ? dead_q - 8'd1 : 8'd0);
      // Gates blank from the step edge itself until dead time has drained.
      if (dead_d == 8'd0) begin
        gateH_d = pwm_q ? tbl[5:3] : 3'd0;
        gateL_d = tbl[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      en_q      <= 1'b0;
      stepCnt_q <= 25'd0;
      S_q       <= 25'd1;
      split_q   <= 2'd0;
      phase_q   <= 3'd0;
      ss_q      <= 1'b0;
      sub_q     <= 23'd0;
      subStep_q <= 2'd0;
      perCnt_q  <= 12'd0;
      L_q       <= 12'd2;
      On_q      <= 12'd0;
      pwm_q     <= 1'b0;
      dead_q    <= 8'd0;
      gateH_q   <= 3'd0;
      gateL_q   <= 3'd0;
    end else begin
      en_q      <= m3c_enable;
      stepCnt_q <= stepCnt_d;
      S_q       <= S_d;
      split_q   <= split_d;
      phase_q   <= phase_d;
      ss_q      <= ss_d;
      sub_q     <= sub_d;
      subStep_q <= subStep_d;
      perCnt_q  <= perCnt_d;
      L_q       <= L_d;
      On_q      <= On_d;
      pwm_q     <= pwm_d;
      dead_q    <= dead_d;
      gateH_q   <= gateH_d;
      gateL_q   <= gateL_d;
    end
  end

  assign m3c_phase     = phase_q;
  assign m3c_stepStart = ss_q;
  assign m3c_subStep   = subStep_q;
  assign m3c_pwmOn     = pwm_q;
  assign m3c_gateH     = gateH_q;
  assign m3c_gateL     = gateL_q;

endmodule

// File: tb/tb_motoro3_commutate.sv
// Directed bench for motoro3_commutate: commutation, sub-steps, PWM duty, dead time, reset.
module tb_motoro3_commutate;

  logic        clk, nRst, en;
  logic [24:0] speed;
  logic [7:0]  pct;
  logic [11:0] len, mask;
  logic [1:0]  split;
  logic [2:0]  phase, gateH, gateL;
  logic        stepStart, pwmOn;
  logic [1:0]  subStep;

  int checks = 0;
  int failures = 0;

  motoro3_commutate #(.DEADTIME(8'd8)) dut (
    .clk(clk), .nRst(nRst), .m3c_enable(en),
    .m3r_stepCNT_speedSET(speed), .m3r_power_percent(pct),
    .m3r_pwmLenWant(len), .m3r_pwmMinMask(mask), .m3r_stepSplitMax(split),
    .m3c_phase(phase), .m3c_stepStart(stepStart), .m3c_subStep(subStep),
    .m3c_pwmOn(pwmOn), .m3c_gateH(gateH), .m3c_gateL(gateL)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] hi_tab(input int ph);
    case (ph)
      0, 1:    hi_tab = 3'b001;
      2, 3:    hi_tab = 3'b010;
      default: hi_tab = 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lo_tab(input int ph);
    case (ph)
      0, 5:    lo_tab = 3'b010;
      1, 2:    lo_tab = 3'b100;
      default: lo_tab = 3'b001;
    endcase
  endfunction

  // First period L=512/On=32, then L=256/On=32 after the mid-period change.
  function automatic logic pwm_main(input int k);
    int c;
    if (k < 1) return 1'b0;
    c = k - 1;
    if (c < 512) return (c < 32);
    return (((c - 512) % 256) < 32);
  endfunction

  task automatic check_parked(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_ss"}, 32'(stepStart), 32'd0);
    chk({tag, "_sub"}, 32'(subStep), 32'd0);
    chk({tag, "_pwm"}, 32'(pwmOn), 32'd0);
    chk({tag, "_gH"}, 32'(gateH), 32'd0);
    chk({tag, "_gL"}, 32'(gateL), 32'd0);
  endtask

  // Re-enable with current settings and check pwmOn held constant over n cycles.
  task automatic run_const_pwm(input string tag, input logic exp, input int n);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk({tag, "_ss0"}, 32'(stepStart), 32'd1);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk($sformatf("%s_pwm_k%0d", tag, k + 1), 32'(pwmOn), 32'(exp));
    end
  endtask

  initial begin
    nRst = 1'b0; en = 1'b0;
    speed = 25'd100; pct = 8'h10; len = 12'd512; mask = 12'd32; split = 2'd3;
    tick();
    tick();
    check_parked("reset");
    nRst = 1'b1;
    tick();
    tick();
    check_parked("idle");

    // Main run: commutation, sub-steps, dead time, mid-period L change, split change.
    en = 1'b1;
    tick();
    for (int k = 0; k < 960; k++) begin
      int st, off, ph, sp, es;
      logic dead, pprev;
      st = k / 100; off = k % 100; ph = st % 6;
      sp = (st >= 2) ? 1 : 3;
      es = off / 25; if (es > sp) es = sp;
      dead = (off < 8);
      pprev = pwm_main(k - 1);
      chk($sformatf("ss_k%0d", k), 32'(stepStart), 32'(off == 0));
      chk($sformatf("phase_k%0d", k), 32'(phase), 32'(ph));
      chk($sformatf("sub_k%0d", k), 32'(subStep), 32'(es));
      chk($sformatf("pwm_k%0d", k), 32'(pwmOn), 32'(pwm_main(k)));
      chk($sformatf("gL_k%0d", k), 32'(gateL), dead ? 32'd0 : 32'(lo_tab(ph)));
      chk($sformatf("gH_k%0d", k), 32'(gateH), (dead || !pprev) ? 32'd0 : 32'(hi_tab(ph)));
      chk($sformatf("overlap_k%0d", k), 32'(gateH & gateL), 32'd0);
      if (k == 100) begin len = 12'd256; pct = 8'h20; end
      if (k == 150) split = 2'd1;
      tick();
    end

    en = 1'b0;
    tick();
    check_parked("disable");
    tick();
    tick();
    check_parked("parked");

    // Full-on, under-mask and zero duty.
    len = 12'd512; mask = 12'd32; split = 2'd3; speed = 25'd100;
    pct = 8'hFF; run_const_pwm("full", 1'b1, 520);
    pct = 8'h0F; run_const_pwm("under", 1'b0, 520);
    pct = 8'h00; run_const_pwm("zero", 1'b0, 520);

    // speedSET=3: q=1, step every 3 clocks, dead time covers the whole step.
    en = 1'b0; tick();
    speed = 25'd3; split = 2'd3; en = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("s3_ss_k%0d", k), 32'(stepStart), 32'(k % 3 == 0));
      chk($sformatf("s3_phase_k%0d", k), 32'(phase), 32'((k / 3) % 6));
      chk($sformatf("s3_sub_k%0d", k), 32'(subStep), 32'(k % 3));
      chk($sformatf("s3_gL_k%0d", k), 32'(gateL), 32'd0);
      tick();
    end

    // speedSET=0 behaves as 1: a step every clock.
    en = 1'b0; tick();
    speed = 25'd0; en = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s0_ss_k%0d", k), 32'(stepStart), 32'd1);
      chk($sformatf("s0_phase_k%0d", k), 32'(phase), 32'(k % 6));
      chk($sformatf("s0_sub_k%0d", k), 32'(subStep), 32'd0);
      tick();
    end

    // Re-enable dead time, then asynchronous reset mid-step.
    en = 1'b0; tick();
    speed = 25'd100; pct = 8'hFF; en = 1'b1;
    tick();
    chk("re_ss", 32'(stepStart), 32'd1);
    chk("re_phase", 32'(phase), 32'd0);
    for (int k = 1; k < 8; k++) tick();
    chk("re_dead_gL_k7", 32'(gateL), 32'd0);
    tick();
    chk("re_gL_k8", 32'(gateL), 32'b010);
    chk("re_gH_k8", 32'(gateH), 32'b001);
    for (int k = 9; k < 20; k++) tick();
    chk("pre_rst_gL", 32'(gateL), 32'b010);
    #10 nRst = 1'b0;
    #1;
    check_parked("async_rst");
    tick();
    nRst = 1'b1; en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
